ddr_axi_tg: RTL and testbench



---
 rtl/ddr_tg_pkg.sv | 21 ++
 rtl/ddr_axi_tg_if.sv | 46 ++++
 rtl/ddr_tg_watchdog.sv | 28 ++
 rtl/ddr_axi_tg.sv | 240 ++++++++++++++++++++++++
 tb/tb_ddr_axi_tg.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_tg_pkg.sv
// Shared types, constants and the data-pattern helper for the DDR AXI traffic generator.
package ddr_tg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } tg_state_e;

  // Address advance per data beat; one controller address unit per 32-bit lane.
  localparam int BEAT_ADDR_STEP = 8;

  // Lane-0 word of a beat; lane k of the same beat carries this value + k.
  function automatic logic [31:0] tg_pattern(input logic [31:0] addr, input logic [3:0] beat);
    return addr + 32'(beat) * 32'(BEAT_ADDR_STEP);
  endfunction

endpackage

// File: rtl/ddr_axi_tg_if.sv
// Command/data bundle between the traffic generator (master) and the DDR controller (slave).
interface ddr_axi_tg_if #(
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int MEM_DQ_WIDTH    = 32
);
  logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr;
  logic [3:0]                 axi_awlen;
  logic [3:0]                 axi_awuser_id;
  logic                       axi_awuser_ap;
  logic                       axi_awvalid;
  logic                       axi_awready;

  logic [CTRL_ADDR_WIDTH-1:0] axi_araddr;
  logic [3:0]                 axi_arlen;
  logic [3:0]                 axi_aruser_id;
  logic                       axi_aruser_ap;
  logic                       axi_arvalid;
  logic                       axi_arready;

  logic [MEM_DQ_WIDTH*8-1:0]  axi_wdata;
  logic [MEM_DQ_WIDTH-1:0]    axi_wstrb;
  logic                       axi_wready;
  logic [3:0]                 axi_wusero_id;
  logic                       axi_wusero_last;

  logic [MEM_DQ_WIDTH*8-1:0]  axi_rdata;
  logic [3:0]                 axi_rid;
  logic                       axi_rlast;
  logic                       axi_rvalid;

  modport master (
    output axi_awaddr, axi_awlen, axi_awuser_id, axi_awuser_ap, axi_awvalid,
    output axi_araddr, axi_arlen, axi_aruser_id, axi_aruser_ap, axi_arvalid,
    output axi_wdata, axi_wstrb,
    input  axi_awready, axi_arready, axi_wready, axi_wusero_id, axi_wusero_last,
    input  axi_rdata, axi_rid, axi_rlast, axi_rvalid
  );

  modport slave (
    input  axi_awaddr, axi_awlen, axi_awuser_id, axi_awuser_ap, axi_awvalid,
    input  axi_araddr, axi_arlen, axi_aruser_id, axi_aruser_ap, axi_arvalid,
    input  axi_wdata, axi_wstrb,
    output axi_awready, axi_arready, axi_wready, axi_wusero_id, axi_wusero_last,
    output axi_rdata, axi_rid, axi_rlast, axi_rvalid
  );
endinterface

// File: rtl/ddr_tg_watchdog.sv
// Stall watchdog: counts cycles without progress and flags when TIMEOUT cycles have elapsed.
module ddr_tg_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic kick_i,
  output logic timeout_o
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en_i || kick_i) begin
      cnt_q <= '0;
    end else if (cnt_q != LAST) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/ddr_axi_tg.sv
// DDR AXI traffic generator: writes NUM_BURSTS patterned bursts, reads them back and counts errors.
// Define DDR_TG_ERR_LOG_EN to capture the address/beat of the first read error in each pass.
module ddr_axi_tg
  import ddr_tg_pkg::*;
#(
  parameter int         CTRL_ADDR_WIDTH = 28,
  parameter int         MEM_DQ_WIDTH    = 32,
  parameter logic [3:0] AXI_LEN         = 4'd15,
  parameter int         NUM_BURSTS      = 16,
  parameter int         TIMEOUT         = 4096
) (
  input  logic                       core_clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       ddr_init_done,
  input  logic [CTRL_ADDR_WIDTH-1:0] base_addr,
  ddr_axi_tg_if.master               axi,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [15:0]                err_cnt,
  output logic [CTRL_ADDR_WIDTH-1:0] first_err_addr,
  output logic [3:0]                 first_err_beat
);
  localparam int          NUM_LANES   = MEM_DQ_WIDTH / 4;
  localparam int          DATA_W      = MEM_DQ_WIDTH * 8;
  localparam int          BURST_BYTES = (int'(AXI_LEN) + 1) * BEAT_ADDR_STEP;
  localparam logic [15:0] LAST_BURST  = 16'(NUM_BURSTS - 1);

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_WR_ADDR = WR_ADDR;
  localparam logic [2:0] ST_WR_DATA = WR_DATA;
  localparam logic [2:0] ST_RD_ADDR = RD_ADDR;
  localparam logic [2:0] ST_RD_DATA = RD_DATA;
  localparam logic [2:0] ST_DONE    = DONE;

  logic [2:0]                 state_q, state_d;
  logic [CTRL_ADDR_WIDTH-1:0] base_q, base_d;
  logic [15:0]                burst_q, burst_d;
  logic [3:0]                 beat_q, beat_d;
  logic [15:0]                err_cnt_q, err_cnt_d;
  logic                       done_q, done_d, err_q, err_d;

  logic [CTRL_ADDR_WIDTH-1:0] burst_addr;
  logic [DATA_W-1:0]          exp_data;
  logic                       last_beat, rd_beat_err, err_inc, beat_evt, kick, timeout;
  logic                       unused_wusero_id;

  assign unused_wusero_id = ^axi.axi_wusero_id;

  assign burst_addr = base_q + CTRL_ADDR_WIDTH'(32'(burst_q) * 32'(BURST_BYTES));
  assign last_beat  = (beat_q == AXI_LEN);
  assign busy       = (state_q == ST_WR_ADDR) || (state_q == ST_WR_DATA) ||
                      (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);

  always_comb begin
    exp_data = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      exp_data[k*32 +: 32] = tg_pattern(32'(burst_addr), beat_q) + 32'(k);
    end
  end

  assign rd_beat_err = (state_q == ST_RD_DATA) && axi.axi_rvalid &&
                       ((axi.axi_rdata != exp_data) || (axi.axi_rid != burst_q[3:0]) ||
                        (axi.axi_rlast && !last_beat));

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    base_d    = base_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    err_cnt_d = err_cnt_q;
    done_d    = done_q;
    err_d     = err_q;
    err_inc   = 1'b0;
    beat_evt  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && ddr_init_done) begin
          state_d   = ST_WR_ADDR;
          base_d    = base_addr;
          burst_d   = '0;
          err_cnt_d = '0;
          done_d    = 1'b0;
          err_d     = 1'b0;
        end
      end
      ST_WR_ADDR: begin
        if (axi.axi_awready) begin
          state_d = ST_WR_DATA;
          beat_d  = '0;
        end else if (timeout) begin
          err_inc = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WR_DATA: begin
        if (axi.axi_wready) begin
          beat_evt = 1'b1;
          err_inc  = (axi.axi_wusero_last != last_beat);
          if (last_beat) begin
            beat_d = '0;
            if (burst_q < LAST_BURST) begin
              burst_d = burst_q + 16'd1;
              state_d = ST_WR_ADDR;
            end else begin
              burst_d = '0;
              state_d = ST_RD_ADDR;
            end
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end else if (timeout) begin
          err_inc = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_RD_ADDR: begin
        if (axi.axi_arready) begin
          state_d = ST_RD_DATA;
          beat_d  = '0;
        end else if (timeout) begin
          err_inc = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_RD_DATA: begin
        if (axi.axi_rvalid) begin
          beat_evt = 1'b1;
          err_inc  = rd_beat_err;
          // An early rlast is already flagged by rd_beat_err and still closes the burst.
          if (axi.axi_rlast) begin
            beat_d = '0;
            if (burst_q < LAST_BURST) begin
              burst_d = burst_q + 16'd1;
              state_d = ST_RD_ADDR;
            end else begin
              burst_d = '0;
              state_d = ST_DONE;
            end
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end else if (timeout) begin
          err_inc = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (err_inc && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;

    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      done_d = 1'b1;
      err_d  = (err_cnt_d != '0);
    end
  end

  assign kick = beat_evt || (state_d != state_q);

  ddr_tg_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (core_clk),
    .rst_n    (resetn),
    .en_i     (busy),
    .kick_i   (kick),
    .timeout_o(timeout)
  );

  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      err_cnt_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      err_cnt_q <= err_cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign done    = done_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

  assign axi.axi_awvalid   = (state_q == ST_WR_ADDR);
  assign axi.axi_awaddr    = (state_q == ST_WR_ADDR) ? burst_addr : '0;
  assign axi.axi_awlen     = AXI_LEN;
  assign axi.axi_awuser_id = burst_q[3:0];
  assign axi.axi_awuser_ap = 1'b1;
  assign axi.axi_arvalid   = (state_q == ST_RD_ADDR);
  assign axi.axi_araddr    = (state_q == ST_RD_ADDR) ? burst_addr : '0;
  assign axi.axi_arlen     = AXI_LEN;
  assign axi.axi_aruser_id = burst_q[3:0];
  assign axi.axi_aruser_ap = 1'b1;
  assign axi.axi_wdata     = (state_q == ST_WR_DATA) ? exp_data : '0;
  assign axi.axi_wstrb     = '1;

`ifdef DDR_TG_ERR_LOG_EN
  logic [CTRL_ADDR_WIDTH-1:0] first_addr_q;
  logic [3:0]                 first_beat_q;
  logic                       logged_q;

  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      first_addr_q <= '0;
      first_beat_q <= '0;
      logged_q     <= 1'b0;
    end else if ((state_q == ST_IDLE) && start && ddr_init_done) begin
      first_addr_q <= '0;
      first_beat_q <= '0;
      logged_q     <= 1'b0;
    end else if (rd_beat_err && !logged_q) begin
      first_addr_q <= burst_addr;
      first_beat_q <= beat_q;
      logged_q     <= 1'b1;
    end
  end

  assign first_err_addr = first_addr_q;
  assign first_err_beat = first_beat_q;
`else
  assign first_err_addr = '0;
  assign first_err_beat = '0;
`endif

endmodule

// File: tb/tb_ddr_axi_tg.sv
// Directed bench for ddr_axi_tg: 2 bursts of 4 beats from base 0x100, controller responder in tasks.
module tb_ddr_axi_tg;
  localparam int         AW  = 28;
  localparam int         DQ  = 32;
  localparam int         DW  = DQ * 8;
  localparam logic [3:0] LEN = 4'd3;
  localparam int         NB  = 2;
  localparam int         TO  = 64;

  logic          core_clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          ddr_init_done = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done, err;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err_addr;
  logic [3:0]    first_err_beat;

  ddr_axi_tg_if #(.CTRL_ADDR_WIDTH(AW), .MEM_DQ_WIDTH(DQ)) axi_if ();

  ddr_axi_tg #(
    .CTRL_ADDR_WIDTH(AW), .MEM_DQ_WIDTH(DQ), .AXI_LEN(LEN), .NUM_BURSTS(NB), .TIMEOUT(TO)
  ) dut (
    .core_clk      (core_clk),
    .resetn        (resetn),
    .start         (start),
    .ddr_init_done (ddr_init_done),
    .base_addr     (base_addr),
    .axi           (axi_if),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .err_cnt       (err_cnt),
    .first_err_addr(first_err_addr),
    .first_err_beat(first_err_beat)
  );

  always #5 core_clk = ~core_clk;

  int            n_checks = 0;
  int            n_pass = 0;
  int            wr_beats = 0;
  logic [DW-1:0] wmem [0:7];

`ifdef DDR_TG_ERR_LOG_EN
  localparam logic [AW-1:0] EXP_FADDR = 28'h120;
  localparam logic [3:0]    EXP_FBEAT = 4'd2;
`else
  localparam logic [AW-1:0] EXP_FADDR = 28'h0;
  localparam logic [3:0]    EXP_FBEAT = 4'd0;
`endif

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Lane k of beat b in burst n: 0x100 + n*32 + b*8 + k.
  function automatic logic [DW-1:0] exp_beat(input int burst, input int beat);
    logic [DW-1:0] r;
    logic [31:0]   a;
    a = 32'h100 + 32'(burst * 32) + 32'(beat * 8);
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = a + 32'(k);
    return r;
  endfunction

  task automatic clear_inputs();
    axi_if.axi_awready     = 1'b0;
    axi_if.axi_arready     = 1'b0;
    axi_if.axi_wready      = 1'b0;
    axi_if.axi_wusero_id   = 4'd0;
    axi_if.axi_wusero_last = 1'b0;
    axi_if.axi_rdata       = '0;
    axi_if.axi_rid         = 4'd0;
    axi_if.axi_rlast       = 1'b0;
    axi_if.axi_rvalid      = 1'b0;
  endtask

  task automatic wait_for(input int sel, input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      case (sel)
        0:       ok = axi_if.axi_awvalid;
        1:       ok = axi_if.axi_arvalid;
        default: ok = done;
      endcase
      if (!ok) @(negedge core_clk);
    end
    check({tag, "_seen"}, 256'(ok), 256'(1));
  endtask

  task automatic pulse_start(input logic [AW-1:0] base);
    base_addr = base;
    start     = 1'b1;
    @(negedge core_clk);
    start     = 1'b0;
  endtask

  task automatic run_pass(input bit alt_w, input bit flip, input bit abort, output bit ok);
    int b;
    int cyc;
    ok = 1'b1;
    for (int n = 0; n < NB; n++) begin
      wait_for(0, "awvalid", ok);
      if (!ok) return;
      check($sformatf("awaddr[%0d]", n), 256'(axi_if.axi_awaddr), 256'(32'h100 + n * 32));
      check($sformatf("awuser_id[%0d]", n), 256'(axi_if.axi_awuser_id), 256'(n));
      check("awlen", 256'(axi_if.axi_awlen), 256'(3));
      axi_if.axi_awready = 1'b1;
      @(negedge core_clk);
      axi_if.axi_awready = 1'b0;
      b = 0;
      cyc = 0;
      while (b < 4 && cyc < 40) begin
        check($sformatf("wdata[%0d][%0d]", n, b), axi_if.axi_wdata, exp_beat(n, b));
        if (!alt_w || (cyc % 2 == 0)) begin
          wmem[n*4 + b]          = axi_if.axi_wdata;
          axi_if.axi_wready      = 1'b1;
          axi_if.axi_wusero_last = (b == 3);
          b++;
          wr_beats++;
        end
        @(negedge core_clk);
        axi_if.axi_wready      = 1'b0;
        axi_if.axi_wusero_last = 1'b0;
        cyc++;
      end
      check($sformatf("wbeats[%0d]", n), 256'(b), 256'(4));
    end
    for (int n = 0; n < NB; n++) begin
      wait_for(1, "arvalid", ok);
      if (!ok) return;
      check($sformatf("araddr[%0d]", n), 256'(axi_if.axi_araddr), 256'(32'h100 + n * 32));
      check($sformatf("aruser_id[%0d]", n), 256'(axi_if.axi_aruser_id), 256'(n));
      axi_if.axi_arready = 1'b1;
      @(negedge core_clk);
      axi_if.axi_arready = 1'b0;
      for (int bb = 0; bb < 4; bb++) begin
        axi_if.axi_rvalid = 1'b1;
        axi_if.axi_rdata  = wmem[n*4 + bb];
        if (flip && n == 1 && bb == 2) axi_if.axi_rdata[31:0] = ~wmem[n*4 + bb][31:0];
        axi_if.axi_rid    = 4'(n);
        axi_if.axi_rlast  = (bb == 3);
        if (abort && n == 0 && bb == 1) return;
        @(negedge core_clk);
      end
      axi_if.axi_rvalid = 1'b0;
      axi_if.axi_rlast  = 1'b0;
    end
  endtask

  task automatic check_result(input string tag, input logic exp_err, input logic [15:0] exp_cnt,
                              input logic [AW-1:0] exp_faddr, input logic [3:0] exp_fbeat);
    bit ok;
    wait_for(2, {tag, "_done"}, ok);
    check({tag, "_done"}, 256'(done), 256'(1));
    check({tag, "_busy"}, 256'(busy), 256'(0));
    check({tag, "_err"}, 256'(err), 256'(exp_err));
    check({tag, "_err_cnt"}, 256'(err_cnt), 256'(exp_cnt));
    check({tag, "_first_err_addr"}, 256'(first_err_addr), 256'(exp_faddr));
    check({tag, "_first_err_beat"}, 256'(first_err_beat), 256'(exp_fbeat));
  endtask

  initial begin
    bit ok;
    int aw_cycles;
    clear_inputs();
    ddr_init_done = 1'b1;
    repeat (2) @(negedge core_clk);

    // Reset state.
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_err", 256'(err), 256'(0));
    check("rst_err_cnt", 256'(err_cnt), 256'(0));
    check("rst_awvalid", 256'(axi_if.axi_awvalid), 256'(0));
    check("rst_arvalid", 256'(axi_if.axi_arvalid), 256'(0));
    check("rst_awaddr", 256'(axi_if.axi_awaddr), 256'(0));
    check("rst_wdata", axi_if.axi_wdata, 256'(0));
    check("rst_first_err_addr", 256'(first_err_addr), 256'(0));
    resetn = 1'b1;
    @(negedge core_clk);

    // Start without controller ready is ignored.
    ddr_init_done = 1'b0;
    pulse_start(28'h100);
    repeat (3) @(negedge core_clk);
    check("noinit_busy", 256'(busy), 256'(0));
    check("noinit_awvalid", 256'(axi_if.axi_awvalid), 256'(0));
    ddr_init_done = 1'b1;

    // Clean pass.
    wr_beats = 0;
    pulse_start(28'h100);
    run_pass(1'b0, 1'b0, 1'b0, ok);
    check_result("clean", 1'b0, 16'd0, '0, 4'd0);
    check("clean_wr_beats", 256'(wr_beats), 256'(8));

    // DONE -> IDLE, then a pass with burst 1 beat 2 lane 0 corrupted on read.
    pulse_start(28'h100);
    check("done2idle_busy", 256'(busy), 256'(0));
    pulse_start(28'h100);
    run_pass(1'b0, 1'b1, 1'b0, ok);
    check_result("flip", 1'b1, 16'd1, EXP_FADDR, EXP_FBEAT);

    // Alternate-cycle wready; error state from the previous pass must be cleared.
    pulse_start(28'h100);
    pulse_start(28'h100);
    run_pass(1'b1, 1'b0, 1'b0, ok);
    check_result("altw", 1'b0, 16'd0, '0, 4'd0);

    // awready never asserted: watchdog fires after TIMEOUT cycles of awvalid.
    pulse_start(28'h100);
    pulse_start(28'h100);
    aw_cycles = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (axi_if.axi_awvalid) aw_cycles++;
      @(negedge core_clk);
    end
    check("to_awvalid_cycles", 256'(aw_cycles), 256'(TO));
    check("to_awvalid_dropped", 256'(axi_if.axi_awvalid), 256'(0));
    check_result("timeout", 1'b1, 16'd1, '0, 4'd0);

    // Reset asserted during read beat 1 of burst 0.
    pulse_start(28'h100);
    pulse_start(28'h100);
    run_pass(1'b0, 1'b0, 1'b1, ok);
    check("pre_abort_busy", 256'(busy), 256'(1));
    #2 resetn = 1'b0;
    #1;
    check("abort_busy", 256'(busy), 256'(0));
    check("abort_done", 256'(done), 256'(0));
    check("abort_err", 256'(err), 256'(0));
    check("abort_err_cnt", 256'(err_cnt), 256'(0));
    check("abort_arvalid", 256'(axi_if.axi_arvalid), 256'(0));
    check("abort_awvalid", 256'(axi_if.axi_awvalid), 256'(0));
    check("abort_araddr", 256'(axi_if.axi_araddr), 256'(0));
    check("abort_wdata", axi_if.axi_wdata, 256'(0));
    @(negedge core_clk);
    clear_inputs();
    resetn = 1'b1;
    @(negedge core_clk);
    check("abort_idle_busy", 256'(busy), 256'(0));
    pulse_start(28'h100);
    run_pass(1'b0, 1'b0, 1'b0, ok);
    check_result("restart", 1'b0, 16'd0, '0, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
